// File: rtl/clock_prescaler.sv
// Programmable clock prescaler: divides CLOCK_50 by 2*N_eff, where
// N_eff = max(PRESCALER,1). CLOCK_X is a 50%-duty registered clock and
// TICK is a registered one-cycle strobe in the cycle after each toggle.
module clock_prescaler #(
    parameter int WIDTH = 27
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [WIDTH-1:0] PRESCALER,
    output logic             CLOCK_X,
    output logic             TICK
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] terminal_count;
    logic             at_terminal;

    // Last count value of a half-period. PRESCALER=0 is treated as 1.
    // The compare is ">=" so a PRESCALER lowered below the running count
    // ends the half-period on the next edge instead of wrapping through
    // the whole counter range.
    always_comb begin
        terminal_count = '0;
        if (PRESCALER != '0) begin
            terminal_count = PRESCALER - 1'b1;
        end
        at_terminal = (count >= terminal_count);
    end

    // Half-period counter, divided clock and toggle strobe; reset wins.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            count   <= '0;
            CLOCK_X <= 1'b0;
            TICK    <= 1'b0;
        end else if (at_terminal) begin
            count   <= '0;
            CLOCK_X <= ~CLOCK_X;
            TICK    <= 1'b1;
        end else begin
            count   <= count + 1'b1;
            TICK    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_prescaler.sv
// Directed bench for clock_prescaler. Expected values are hand-derived
// from edge counts after reset release.
module tb_clock_prescaler;

    localparam int WIDTH = 27;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] prescaler;
    logic             clock_x;
    logic             tick;

    int n_vec;
    int n_err;

    clock_prescaler #(.WIDTH(WIDTH)) dut (
        .CLOCK_50  (clk),
        .RESET     (rst),
        .PRESCALER (prescaler),
        .CLOCK_X   (clock_x),
        .TICK      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        step(n);
        rst = 1'b0;
    endtask

    int ticks;
    int high_cycles;
    int rises;
    logic prev_x;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        prescaler = 27'd4;

        // 1: reset held 3 cycles, then 4 high / 4 low with TICK every 4
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rst_clock_x", {31'd0, clock_x}, 32'd0);
            chk("rst_tick", {31'd0, tick}, 32'd0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk("p4_clock_x", {31'd0, clock_x}, ((k / 4) % 2));
            chk("p4_tick", {31'd0, tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // 2: PRESCALER=0 and PRESCALER=1 both divide by 2 with TICK stuck high
        prescaler = 27'd0;
        do_reset(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("p0_clock_x", {31'd0, clock_x}, k % 2);
            chk("p0_tick", {31'd0, tick}, 32'd1);
        end
        prescaler = 27'd1;
        do_reset(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk("p1_clock_x", {31'd0, clock_x}, k % 2);
            chk("p1_tick", {31'd0, tick}, 32'd1);
        end

        // 3: PRESCALER=10, lowered to 3 at count=7 -> toggle on next edge
        prescaler = 27'd10;
        do_reset(1);
        step(7);
        chk("drop_pre_x", {31'd0, clock_x}, 32'd0);
        chk("drop_pre_tick", {31'd0, tick}, 32'd0);
        prescaler = 27'd3;
        step(1);
        chk("drop_toggle_x", {31'd0, clock_x}, 32'd1);
        chk("drop_toggle_tick", {31'd0, tick}, 32'd1);
        step(2);
        chk("drop_hold_x", {31'd0, clock_x}, 32'd1);
        chk("drop_hold_tick", {31'd0, tick}, 32'd0);
        step(1);
        chk("drop_fall_x", {31'd0, clock_x}, 32'd0);
        chk("drop_fall_tick", {31'd0, tick}, 32'd1);
        step(3);
        chk("drop_rise_x", {31'd0, clock_x}, 32'd1);
        chk("drop_rise_tick", {31'd0, tick}, 32'd1);

        // 4: PRESCALER=3, raised to 6 at count=1 -> half-period of 6
        prescaler = 27'd3;
        do_reset(1);
        step(1);
        prescaler = 27'd6;
        for (int k = 2; k <= 5; k++) begin
            step(1);
            chk("raise_low_x", {31'd0, clock_x}, 32'd0);
            chk("raise_low_tick", {31'd0, tick}, 32'd0);
        end
        step(1);
        chk("raise_rise_x", {31'd0, clock_x}, 32'd1);
        chk("raise_rise_tick", {31'd0, tick}, 32'd1);
        step(5);
        chk("raise_hold_x", {31'd0, clock_x}, 32'd1);
        step(1);
        chk("raise_fall_x", {31'd0, clock_x}, 32'd0);

        // 5: 1-cycle reset mid high half-period restarts the count
        prescaler = 27'd4;
        do_reset(1);
        step(6);
        chk("midrst_pre_x", {31'd0, clock_x}, 32'd1);
        do_reset(1);
        chk("midrst_x", {31'd0, clock_x}, 32'd0);
        chk("midrst_tick", {31'd0, tick}, 32'd0);
        step(3);
        chk("midrst_wait_x", {31'd0, clock_x}, 32'd0);
        step(1);
        chk("midrst_rise_x", {31'd0, clock_x}, 32'd1);
        chk("midrst_rise_tick", {31'd0, tick}, 32'd1);

        // 6: long run, 2 full periods -> 4 ticks, 2 rises, 50% duty
        prescaler = 27'd5000;
        do_reset(1);
        ticks       = 0;
        high_cycles = 0;
        rises       = 0;
        prev_x      = clock_x;
        for (int k = 1; k <= 20000; k++) begin
            step(1);
            ticks       += int'(tick);
            high_cycles += int'(clock_x);
            if (clock_x && !prev_x) rises++;
            prev_x = clock_x;
        end
        chk("long_ticks", ticks, 32'd4);
        chk("long_rises", rises, 32'd2);
        chk("long_high", high_cycles, 32'd10000);
        chk("long_end_x", {31'd0, clock_x}, 32'd0);

        // Maximum PRESCALER: counter runs without an early toggle
        prescaler = {WIDTH{1'b1}};
        do_reset(1);
        ticks = 0;
        for (int k = 1; k <= 200; k++) begin
            step(1);
            ticks += int'(tick);
        end
        chk("max_no_tick", ticks, 32'd0);
        chk("max_clock_x", {31'd0, clock_x}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
